// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with req/ack bus handshake, access timeout and exception merge.
// Define MEM_ALIGN_CHECK_EN to raise ADEL/ADES on non-word-aligned addresses.
//
// state | meaning
// IDLE  | no bus access outstanding; a valid access starts here
// WAIT  | request on the bus, waiting for ack or timeout
// DRAIN | slot flushed mid-access; keep request up until ack, drop the data
// DONE  | one-cycle completion slot, load data / bus error visible
module mem_stage #(
  parameter int unsigned TIMEOUT         = 255,
  parameter int unsigned REG_SRC_LENGTH  = 2,
  parameter int unsigned EXC_TYPE_LENGTH = 4,
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_DEFAULT = 4'd0,
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADEL    = 4'd4,
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADES    = 4'd5,
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_DBE     = 4'd7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                alu_result_in,
  input  logic [31:0]                reg2_data_in,
  input  logic [4:0]                 dst_reg_in,
  input  logic [31:0]                pc_in,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       cp0_write_in,
  input  logic                       reg_write_in,
  input  logic [REG_SRC_LENGTH-1:0]  reg_src_in,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_type_in,
  input  logic                       bubble_in,
  input  logic                       flush_in,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [31:0]                dmem_addr,
  output logic [31:0]                dmem_wdata,
  input  logic                       dmem_ack,
  input  logic [31:0]                dmem_rdata,
  output logic                       stall_req,
  output logic [31:0]                mem_data_out,
  output logic [31:0]                alu_result_out,
  output logic [31:0]                pc_out,
  output logic [4:0]                 dst_reg_out,
  output logic [REG_SRC_LENGTH-1:0]  reg_src_out,
  output logic                       bubble_out,
  output logic                       reg_write_out,
  output logic                       cp0_write_out,
  output logic [EXC_TYPE_LENGTH-1:0] exc_type_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [1:0] ADDR_LO_MASK = 2'b11;
`else
  localparam logic [1:0] ADDR_LO_MASK = 2'b00;
`endif

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic candidate, misaligned, valid_access, bus_err_now, new_exc;

  assign candidate = (mem_read_in | mem_write_in) & ~bubble_in &
                     (exc_type_in == EXC_TYPE_DEFAULT) & ~flush_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = candidate & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign valid_access = candidate & ~misaligned;

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    mem_data_d   = mem_data_q;
    cnt_d        = cnt_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (valid_access) begin
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write_in;
          dmem_addr_d  = {alu_result_in[31:2], alu_result_in[1:0] & ADDR_LO_MASK};
          dmem_wdata_d = reg2_data_in;
          cnt_d        = 8'd0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          if (!dmem_we_q) mem_data_d = dmem_rdata;
          dmem_req_d = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush_in) state_d = S_DRAIN;
        end
      end
      // the bus transaction must complete even though its result is dropped
      S_DRAIN: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_DONE: begin
        bus_err_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      mem_data_q   <= 32'd0;
      cnt_q        <= 8'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      mem_data_q   <= mem_data_d;
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // reset drops the request in the same cycle, ahead of the register
  assign dmem_req   = dmem_req_q & ~rst;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

  assign stall_req = ~rst & (((state_q == S_IDLE) & valid_access) |
                             (state_q == S_WAIT) | (state_q == S_DRAIN));

  assign bus_err_now = (state_q == S_DONE) & bus_err_q;
  assign new_exc     = misaligned | bus_err_now;

  always_comb begin
    exc_type_out = exc_type_in;
    if (bus_err_now)      exc_type_out = EXC_TYPE_DBE;
    else if (misaligned)  exc_type_out = mem_read_in ? EXC_TYPE_ADEL : EXC_TYPE_ADES;
  end

  assign mem_data_out   = mem_data_q;
  assign alu_result_out = alu_result_in;
  assign pc_out         = pc_in;
  assign dst_reg_out    = dst_reg_in;
  assign reg_src_out    = reg_src_in;
  assign bubble_out     = bubble_in;
  assign reg_write_out  = reg_write_in & ~new_exc;
  assign cp0_write_out  = cp0_write_in & ~new_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: two instances (TIMEOUT 255 and 4) share all inputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, reg2_data_in, pc_in, dmem_rdata;
  logic [4:0]  dst_reg_in;
  logic        mem_read_in, mem_write_in, cp0_write_in, reg_write_in;
  logic [1:0]  reg_src_in;
  logic [3:0]  exc_type_in;
  logic        bubble_in, flush_in, dmem_ack;

  logic        dmem_req, dmem_we, stall_req, bubble_out, reg_write_out, cp0_write_out;
  logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out, pc_out;
  logic [4:0]  dst_reg_out;
  logic [1:0]  reg_src_out;
  logic [3:0]  exc_type_out;

  logic        t_dmem_req, t_dmem_we, t_stall_req, t_bubble_out, t_reg_write_out, t_cp0_write_out;
  logic [31:0] t_dmem_addr, t_dmem_wdata, t_mem_data_out, t_alu_result_out, t_pc_out;
  logic [4:0]  t_dst_reg_out;
  logic [1:0]  t_reg_src_out;
  logic [3:0]  t_exc_type_out;

  localparam logic [3:0] EXC_DEF = 4'd0, EXC_ADEL = 4'd4, EXC_ADES = 4'd5, EXC_DBE = 4'd7;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk(clk), .rst(rst), .alu_result_in(alu_result_in), .reg2_data_in(reg2_data_in),
    .dst_reg_in(dst_reg_in), .pc_in(pc_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .cp0_write_in(cp0_write_in), .reg_write_in(reg_write_in), .reg_src_in(reg_src_in),
    .exc_type_in(exc_type_in), .bubble_in(bubble_in), .flush_in(flush_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_req(stall_req),
    .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .pc_out(pc_out),
    .dst_reg_out(dst_reg_out), .reg_src_out(reg_src_out), .bubble_out(bubble_out),
    .reg_write_out(reg_write_out), .cp0_write_out(cp0_write_out), .exc_type_out(exc_type_out)
  );

  mem_stage #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .alu_result_in(alu_result_in), .reg2_data_in(reg2_data_in),
    .dst_reg_in(dst_reg_in), .pc_in(pc_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .cp0_write_in(cp0_write_in), .reg_write_in(reg_write_in), .reg_src_in(reg_src_in),
    .exc_type_in(exc_type_in), .bubble_in(bubble_in), .flush_in(flush_in),
    .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr), .dmem_wdata(t_dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_req(t_stall_req),
    .mem_data_out(t_mem_data_out), .alu_result_out(t_alu_result_out), .pc_out(t_pc_out),
    .dst_reg_out(t_dst_reg_out), .reg_src_out(t_reg_src_out), .bubble_out(t_bubble_out),
    .reg_write_out(t_reg_write_out), .cp0_write_out(t_cp0_write_out), .exc_type_out(t_exc_type_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_in = 0; mem_write_in = 0; bubble_in = 0; flush_in = 0;
    exc_type_in = EXC_DEF; dmem_ack = 0; reg_write_in = 0; cp0_write_in = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    alu_result_in = 0; reg2_data_in = 0; pc_in = 0; dmem_rdata = 0; dst_reg_in = 0;
    reg_src_in = 0;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    chk("rst_stall", {31'd0, stall_req}, 0);
    chk("rst_req", {31'd0, dmem_req}, 0);
    rst = 0;
    #1;
    chk("rst_we", {31'd0, dmem_we}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_mdata", mem_data_out, 0);

    // zero-wait load
    alu_result_in = 32'h100; mem_read_in = 1; reg_write_in = 1; cp0_write_in = 1;
    pc_in = 32'h400; dst_reg_in = 5'd5; reg_src_in = 2'd2;
    #1;
    chk("ld_idle_stall", {31'd0, stall_req}, 1);
    chk("ld_idle_req", {31'd0, dmem_req}, 0);
    chk("ld_pc", pc_out, 32'h400);
    chk("ld_dst", {27'd0, dst_reg_out}, 5);
    chk("ld_alu", alu_result_out, 32'h100);
    chk("ld_src", {30'd0, reg_src_out}, 2);
    tick();
    chk("ld_wait_req", {31'd0, dmem_req}, 1);
    chk("ld_wait_we", {31'd0, dmem_we}, 0);
    chk("ld_wait_addr", dmem_addr, 32'h100);
    chk("ld_wait_stall", {31'd0, stall_req}, 1);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    chk("ld_done_req", {31'd0, dmem_req}, 0);
    chk("ld_done_stall", {31'd0, stall_req}, 0);
    chk("ld_done_data", mem_data_out, 32'hDEADBEEF);
    chk("ld_done_exc", {28'd0, exc_type_out}, EXC_DEF);
    chk("ld_done_rw", {31'd0, reg_write_out}, 1);
    chk("ld_done_cp0", {31'd0, cp0_write_out}, 1);
    idle_inputs();
    tick();
    chk("ld_after_stall", {31'd0, stall_req}, 0);

    // store with ack in the fifth WAIT cycle
    alu_result_in = 32'h200; reg2_data_in = 32'h12345678; mem_write_in = 1;
    #1;
    chk("st_idle_stall", {31'd0, stall_req}, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("st_wait_req", {31'd0, dmem_req}, 1);
      chk("st_wait_we", {31'd0, dmem_we}, 1);
      chk("st_wait_addr", dmem_addr, 32'h200);
      chk("st_wait_wdata", dmem_wdata, 32'h12345678);
      chk("st_wait_stall", {31'd0, stall_req}, 1);
      if (i == 4) begin
        dmem_ack = 1; dmem_rdata = 32'hAAAA5555;
      end
      tick();
    end
    chk("st_done_stall", {31'd0, stall_req}, 0);
    chk("st_done_req", {31'd0, dmem_req}, 0);
    chk("st_done_data", mem_data_out, 32'hDEADBEEF);
    idle_inputs();
    tick();

    // upstream exception and bubble suppress the access
    alu_result_in = 32'h300; mem_read_in = 1; reg_write_in = 1; exc_type_in = 4'd3;
    #1;
    chk("upexc_stall", {31'd0, stall_req}, 0);
    chk("upexc_exc", {28'd0, exc_type_out}, 3);
    chk("upexc_rw", {31'd0, reg_write_out}, 1);
    exc_type_in = EXC_DEF; bubble_in = 1;
    #1;
    chk("bubble_stall", {31'd0, stall_req}, 0);
    chk("bubble_out", {31'd0, bubble_out}, 1);
    tick();
    chk("bubble_req", {31'd0, dmem_req}, 0);
    idle_inputs();

    // misaligned load at 0x102
    alu_result_in = 32'h102; mem_read_in = 1; reg_write_in = 1; cp0_write_in = 1;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_ld_stall", {31'd0, stall_req}, 0);
    chk("mis_ld_exc", {28'd0, exc_type_out}, EXC_ADEL);
    chk("mis_ld_rw", {31'd0, reg_write_out}, 0);
    chk("mis_ld_cp0", {31'd0, cp0_write_out}, 0);
    tick();
    chk("mis_ld_req", {31'd0, dmem_req}, 0);
    mem_read_in = 0; mem_write_in = 1; alu_result_in = 32'h203;
    #1;
    chk("mis_st_exc", {28'd0, exc_type_out}, EXC_ADES);
    chk("mis_st_stall", {31'd0, stall_req}, 0);
    tick();
    chk("mis_st_req", {31'd0, dmem_req}, 0);
`else
    chk("mis_ld_stall", {31'd0, stall_req}, 1);
    chk("mis_ld_exc", {28'd0, exc_type_out}, EXC_DEF);
    chk("mis_ld_rw", {31'd0, reg_write_out}, 1);
    tick();
    chk("mis_ld_addr", dmem_addr, 32'h100);
    chk("mis_ld_req", {31'd0, dmem_req}, 1);
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    tick();
    chk("mis_ld_data", mem_data_out, 32'hCAFEF00D);
`endif
    idle_inputs();

    // timeout on the TIMEOUT=4 instance
    do_reset();
    alu_result_in = 32'h300; mem_read_in = 1; reg_write_in = 1; cp0_write_in = 1;
    #1;
    chk("to_idle_stall", {31'd0, t_stall_req}, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_req", {31'd0, t_dmem_req}, 1);
      chk("to_wait_stall", {31'd0, t_stall_req}, 1);
      tick();
    end
    chk("to_done_req", {31'd0, t_dmem_req}, 0);
    chk("to_done_stall", {31'd0, t_stall_req}, 0);
    chk("to_done_exc", {28'd0, t_exc_type_out}, EXC_DBE);
    chk("to_done_rw", {31'd0, t_reg_write_out}, 0);
    chk("to_done_cp0", {31'd0, t_cp0_write_out}, 0);
    chk("to_big_req", {31'd0, dmem_req}, 1);
    idle_inputs();
    tick();
    chk("to_idle_exc", {28'd0, t_exc_type_out}, EXC_DEF);
    dmem_ack = 1; dmem_rdata = 32'h99999999;
    tick();
    chk("to_stray_req", {31'd0, t_dmem_req}, 0);
    chk("to_stray_stall", {31'd0, t_stall_req}, 0);
    chk("to_stray_data", t_mem_data_out, 0);
    chk("to_stray_exc", {28'd0, t_exc_type_out}, EXC_DEF);
    dmem_ack = 0;

    // flush during the second WAIT cycle, ack three cycles later
    do_reset();
    alu_result_in = 32'h140; mem_read_in = 1;
    tick();
    dmem_ack = 1; dmem_rdata = 32'h11112222;
    tick();
    chk("fl_pre_data", mem_data_out, 32'h11112222);
    idle_inputs();
    tick();
    alu_result_in = 32'h180; mem_read_in = 1;
    tick();
    chk("fl_wait1_req", {31'd0, dmem_req}, 1);
    tick();
    flush_in = 1;
    #1;
    chk("fl_wait2_stall", {31'd0, stall_req}, 1);
    tick();
    flush_in = 0;
    for (int i = 0; i < 3; i++) begin
      chk("fl_drain_req", {31'd0, dmem_req}, 1);
      chk("fl_drain_stall", {31'd0, stall_req}, 1);
      chk("fl_drain_addr", dmem_addr, 32'h180);
      if (i == 2) begin
        dmem_ack = 1; dmem_rdata = 32'h55555555;
      end
      tick();
    end
    idle_inputs();
    #1;
    chk("fl_end_req", {31'd0, dmem_req}, 0);
    chk("fl_end_stall", {31'd0, stall_req}, 0);
    chk("fl_end_data", mem_data_out, 32'h11112222);
    tick();
    chk("fl_idle_req", {31'd0, dmem_req}, 0);

    // reset in the middle of WAIT
    alu_result_in = 32'h1C0; reg2_data_in = 32'h0BADF00D; mem_write_in = 1;
    tick();
    chk("rw_wait_req", {31'd0, dmem_req}, 1);
    rst = 1;
    #1;
    chk("rw_req_now", {31'd0, dmem_req}, 0);
    chk("rw_stall_now", {31'd0, stall_req}, 0);
    tick();
    chk("rw_req", {31'd0, dmem_req}, 0);
    chk("rw_we", {31'd0, dmem_we}, 0);
    chk("rw_addr", dmem_addr, 0);
    chk("rw_wdata", dmem_wdata, 0);
    chk("rw_data", mem_data_out, 0);
    idle_inputs();
    rst = 0;
    #1;
    chk("rw_stall", {31'd0, stall_req}, 0);
    tick();
    chk("rw_idle_req", {31'd0, dmem_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
